// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I load or store at a time, checks width and alignment,
// drives a single-cycle access to a byte-addressed memory with registered read data.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module load_store_unit #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int WORD_WIDTH = `WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [2:0]            funct3,
    input  logic [WORD_WIDTH-1:0] baseAddr,
    input  logic [WORD_WIDTH-1:0] offset,
    input  logic [WORD_WIDTH-1:0] storeData,
    output logic                  respValid,
    output logic                  respError,
    output logic [WORD_WIDTH-1:0] loadData,
    output logic                  memRead,
    output logic                  memWrite,
    output logic [1:0]            addrUnit,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] memDataOut,
    input  logic [WORD_WIDTH-1:0] memDataIn
);

    localparam logic [1:0] UNIT_BYTE = 2'b00;
    localparam logic [1:0] UNIT_HALF = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [WORD_WIDTH-1:0]   w_eff_full;
    logic [ADDR_WIDTH-1:0]   w_eff_addr;
    logic                    w_unused_eff;
    logic                    w_illegal;
    logic                    w_accept;

    logic                    r_mem_read;
    logic                    r_mem_write;
    logic [1:0]              r_addr_unit;
    logic [ADDR_WIDTH-1:0]   r_address;
    logic [WORD_WIDTH-1:0]   r_mem_data_out;
    logic                    r_signed;
    logic                    r_is_write;
    logic                    r_resp_error;
    logic [WORD_WIDTH-1:0]   r_load_data;

    // Sign or zero extension of the captured read data according to access width.
    function automatic logic [WORD_WIDTH-1:0] extend_load(
        input logic [1:0]            unit,
        input logic                  sgn,
        input logic [WORD_WIDTH-1:0] data
    );
        logic [WORD_WIDTH-1:0] result;
        case (unit)
            UNIT_BYTE: result = {{(WORD_WIDTH-8){sgn & data[7]}}, data[7:0]};
            UNIT_HALF: result = {{(WORD_WIDTH-16){sgn & data[15]}}, data[15:0]};
            default:   result = data;
        endcase
        return result;
    endfunction

    assign w_eff_full   = baseAddr + offset;
    assign w_eff_addr   = w_eff_full[ADDR_WIDTH-1:0];
    assign w_unused_eff = ^w_eff_full;
    assign w_accept     = reqValid & (r_state == S_IDLE);

    // Legality of the width code for the request direction, and natural alignment.
    always_comb begin
        w_illegal = 1'b1;
        case (funct3)
            3'b000:  w_illegal = 1'b0;
            3'b001:  w_illegal = w_eff_addr[0];
            3'b010:  w_illegal = |w_eff_addr[1:0];
            3'b100:  w_illegal = reqWrite;
            3'b101:  w_illegal = reqWrite | w_eff_addr[0];
            default: w_illegal = 1'b1;
        endcase
    end

    // Next-state logic; errors skip the memory access entirely.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_illegal ? S_RESP : S_ACCESS;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ACCESS:  w_next_state = r_is_write ? S_RESP : S_CAPTURE;
            S_CAPTURE: w_next_state = S_RESP;
            S_RESP:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Memory-side and response registers; strobes default low so they last one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_addr_unit    <= 2'b00;
            r_address      <= '0;
            r_mem_data_out <= '0;
            r_signed       <= 1'b0;
            r_is_write     <= 1'b0;
            r_resp_error   <= 1'b0;
            r_load_data    <= '0;
        end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_resp_error <= 1'b1;
                            r_load_data  <= '0;
                        end else begin
                            r_address      <= w_eff_addr;
                            r_addr_unit    <= funct3[1:0];
                            r_mem_data_out <= storeData;
                            r_signed       <= ~funct3[2];
                            r_is_write     <= reqWrite;
                            r_mem_read     <= ~reqWrite;
                            r_mem_write    <= reqWrite;
                        end
                    end
                end
                S_ACCESS: begin
                    // A store's response is produced here; a load's after capture.
                    if (r_is_write) begin
                        r_resp_error <= 1'b0;
                        r_load_data  <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_resp_error <= 1'b0;
                    r_load_data  <= extend_load(r_addr_unit, r_signed, memDataIn);
                end
                default: begin
                    r_resp_error <= r_resp_error;
                end
            endcase
        end
    end

    assign reqReady   = (r_state == S_IDLE);
    assign respValid  = (r_state == S_RESP);
    assign respError  = r_resp_error;
    assign loadData   = r_load_data;
    assign memRead    = r_mem_read;
    assign memWrite   = r_mem_write;
    assign addrUnit   = r_addr_unit;
    assign address    = r_address;
    assign memDataOut = r_mem_data_out;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed registered-read memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [2:0]  funct3;
    logic [31:0] baseAddr;
    logic [31:0] offset;
    logic [31:0] storeData;
    logic        respValid;
    logic        respError;
    logic [31:0] loadData;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  addrUnit;
    logic [15:0] address;
    logic [31:0] memDataOut;
    logic [31:0] memDataIn;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] mem [0:1023];

    load_store_unit #(.ADDR_WIDTH(16), .WORD_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady),
        .reqWrite(reqWrite), .funct3(funct3), .baseAddr(baseAddr), .offset(offset),
        .storeData(storeData), .respValid(respValid), .respError(respError),
        .loadData(loadData), .memRead(memRead), .memWrite(memWrite),
        .addrUnit(addrUnit), .address(address), .memDataOut(memDataOut),
        .memDataIn(memDataIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: little-endian writes, one-cycle registered reads.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        memDataIn = 32'h0;
    end
    always @(posedge clk) begin
        if (memWrite) begin
            mem[address[9:0]] <= memDataOut[7:0];
            if (addrUnit != 2'b00) mem[address[9:0] + 10'd1] <= memDataOut[15:8];
            if (addrUnit == 2'b10) begin
                mem[address[9:0] + 10'd2] <= memDataOut[23:16];
                mem[address[9:0] + 10'd3] <= memDataOut[31:24];
            end
        end
        if (memRead) begin
            case (addrUnit)
                2'b00:   memDataIn <= {24'h0, mem[address[9:0]]};
                2'b01:   memDataIn <= {16'h0, mem[address[9:0] + 10'd1], mem[address[9:0]]};
                default: memDataIn <= {mem[address[9:0] + 10'd3], mem[address[9:0] + 10'd2],
                                       mem[address[9:0] + 10'd1], mem[address[9:0]]};
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) check("rd_wr_excl", {31'h0, memRead & memWrite}, 32'h0);

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"}, {31'h0, reqReady}, 32'h1);
        check({tag, "_ctl"}, {26'h0, respValid, respError, memRead, memWrite, addrUnit}, 32'h0);
        check({tag, "_ldata"}, loadData, 32'h0);
        check({tag, "_addr"}, {16'h0, address}, 32'h0);
        check({tag, "_mdo"}, memDataOut, 32'h0);
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (!reqReady && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (!reqReady) check({tag, "_ready_to"}, 32'h0, 32'h1);
    endtask

    // Issue one request and check latency, strobes, access address/unit and result.
    task automatic issue(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] sd,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_data,
                         input logic [15:0] exp_addr, input logic [1:0] exp_unit);
        int lat = 0;
        int n_rd = 0;
        int n_wr = 0;
        logic [15:0] seen_addr = 16'h0;
        logic [1:0]  seen_unit = 2'b11;
        @(negedge clk);
        wait_ready(tag);
        reqValid = 1'b1; reqWrite = wr; funct3 = f3;
        baseAddr = base; offset = off; storeData = sd;
        @(posedge clk);
        #1 reqValid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (memRead)  n_rd++;
            if (memWrite) n_wr++;
            if (memRead | memWrite) begin
                seen_addr = address;
                seen_unit = addrUnit;
            end
            if (respValid) begin
                lat = c;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, {31'h0, respError}, {31'h0, exp_err});
        check({tag, "_nrd"}, n_rd, (!exp_err && !wr) ? 1 : 0);
        check({tag, "_nwr"}, n_wr, (!exp_err && wr) ? 1 : 0);
        if (exp_err || !wr) check({tag, "_data"}, loadData, exp_data);
        if (!exp_err) begin
            check({tag, "_addr"}, {16'h0, seen_addr}, {16'h0, exp_addr});
            check({tag, "_unit"}, {30'h0, seen_unit}, {30'h0, exp_unit});
        end
    endtask

    int hs [3];
    logic [31:0] b2b_data [3];

    initial begin
        rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; funct3 = 3'b000;
        baseAddr = 32'h0; offset = 32'h0; storeData = 32'h0;
        #1 check_reset_outs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Word store then load back.
        issue("sw104", 1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 2, 1'b0, 32'h0, 16'h104, 2'b10);
        issue("lw104", 1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 3, 1'b0, 32'hDEADBEEF, 16'h104, 2'b10);

        // Byte and halfword extension.
        issue("sb20", 1'b1, 3'b000, 32'h20, 32'h0, 32'h12345680, 2, 1'b0, 32'h0, 16'h20, 2'b00);
        issue("lb20", 1'b0, 3'b000, 32'h20, 32'h0, 32'h0, 3, 1'b0, 32'hFFFFFF80, 16'h20, 2'b00);
        issue("lbu20", 1'b0, 3'b100, 32'h20, 32'h0, 32'h0, 3, 1'b0, 32'h00000080, 16'h20, 2'b00);
        issue("sh22", 1'b1, 3'b001, 32'h20, 32'h2, 32'hAAAA8001, 2, 1'b0, 32'h0, 16'h22, 2'b01);
        issue("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 32'h0, 3, 1'b0, 32'hFFFF8001, 16'h22, 2'b01);
        issue("lhu22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h0, 3, 1'b0, 32'h00008001, 16'h22, 2'b01);
        issue("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 3, 1'b0, 32'h80010080, 16'h20, 2'b10);

        // Negative offset.
        issue("sw0c", 1'b1, 3'b010, 32'h0, 32'hC, 32'hCAFEF00D, 2, 1'b0, 32'h0, 16'h0C, 2'b10);
        issue("lwneg", 1'b0, 3'b010, 32'h10, 32'hFFFFFFFC, 32'h0, 3, 1'b0, 32'hCAFEF00D, 16'h0C, 2'b10);

        // Misaligned and illegal width codes.
        issue("lh101", 1'b0, 3'b001, 32'h100, 32'h1, 32'h0, 1, 1'b1, 32'h0, 16'h0, 2'b00);
        issue("lw102", 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 1'b1, 32'h0, 16'h0, 2'b00);
        issue("sw103", 1'b1, 3'b010, 32'h103, 32'h0, 32'h1, 1, 1'b1, 32'h0, 16'h0, 2'b00);
        issue("lf011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1'b1, 32'h0, 16'h0, 2'b00);
        issue("sf100", 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1, 1'b1, 32'h0, 16'h0, 2'b00);
        issue("lw104b", 1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 3, 1'b0, 32'hDEADBEEF, 16'h104, 2'b10);

        // Back-to-back loads with reqValid held high.
        b2b_data[0] = 32'h01020304; b2b_data[1] = 32'hA5A55A5A; b2b_data[2] = 32'h7FFF0001;
        issue("pre200", 1'b1, 3'b010, 32'h200, 32'h0, b2b_data[0], 2, 1'b0, 32'h0, 16'h200, 2'b10);
        issue("pre204", 1'b1, 3'b010, 32'h200, 32'h4, b2b_data[1], 2, 1'b0, 32'h0, 16'h204, 2'b10);
        issue("pre208", 1'b1, 3'b010, 32'h200, 32'h8, b2b_data[2], 2, 1'b0, 32'h0, 16'h208, 2'b10);
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b0; funct3 = 3'b010; offset = 32'h0;
        for (int k = 0; k < 3; k++) begin
            baseAddr = 32'h200 + 32'(4 * k);
            wait_ready("b2b");
            @(posedge clk);
            hs[k] = cyc;
            #1;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                check("b2b_busy", {31'h0, reqReady}, 32'h0);
            end
            check("b2b_valid", {31'h0, respValid}, 32'h1);
            check("b2b_data", loadData, b2b_data[k]);
        end
        reqValid = 1'b0;
        check("b2b_gap1", hs[1] - hs[0], 4);
        check("b2b_gap2", hs[2] - hs[1], 4);

        // Reset during the access cycle of a store.
        issue("sw40", 1'b1, 3'b010, 32'h40, 32'h0, 32'h11223344, 2, 1'b0, 32'h0, 16'h40, 2'b10);
        @(negedge clk);
        wait_ready("rst");
        reqValid = 1'b1; reqWrite = 1'b1; funct3 = 3'b010;
        baseAddr = 32'h40; offset = 32'h0; storeData = 32'h55;
        @(posedge clk);
        #1 reqValid = 1'b0;
        #2 check("rst_pre_wr", {31'h0, memWrite}, 32'h1);
        rst_n = 1'b0;
        #1 check_reset_outs("midrst");
        @(posedge clk);
        @(negedge clk);
        check_reset_outs("rsthold");
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_noresp", {31'h0, respValid}, 32'h0);
        end
        issue("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 3, 1'b0, 32'h11223344, 16'h40, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
